// File: rtl/downsampler_2x2.sv
// downsampler_2x2: 2x2 box-average decimator feeding the half-resolution FIFO.
// One pixel in per cycle; one rounded average out per 2x2 block, a cycle later.
module downsampler_2x2 #(
   parameter int NUMCOL = 800,
   parameter int NUMROW = 600
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       valid,
   input  logic [7:0] data,
   input  logic       fifo_full,
   output logic       fifo_write,
   output logic [7:0] dataout,
   output logic [8:0] out_colcount,
   output logic [8:0] out_rowcount,
   output logic       frame_done,
   output logic       overflow
);

   localparam int HALFC = NUMCOL / 2;
   localparam int AW = $clog2(HALFC);
   localparam logic [9:0] LASTC = 10'(NUMCOL - 1);
   localparam logic [9:0] LASTR = 10'(NUMROW - 1);

   logic [9:0]    r_col;
   logic [9:0]    r_row;
   logic [7:0]    r_hold;
   logic [8:0]    r_lbuf [HALFC];
   logic [8:0]    r_above;
   logic          r_pend;
   logic [7:0]    r_dout;
   logic [8:0]    r_ocol;
   logic [8:0]    r_orow;
   logic          r_fdone;
   logic          r_ovf;

   logic [AW-1:0] w_idx;
   logic          w_col_odd;
   logic          w_row_odd;
   logic          w_last_col;
   logic          w_last_row;
   logic          w_emit;
   logic          w_lb_wr;
   logic          w_lb_rd;
   logic [8:0]    w_pair;
   logic [9:0]    w_sum;
   logic [7:0]    w_avg;

   assign w_idx      = r_col[AW:1];
   assign w_col_odd  = r_col[0];
   assign w_row_odd  = r_row[0];
   assign w_last_col = (r_col == LASTC);
   assign w_last_row = (r_row == LASTR);

   assign w_pair = {1'b0, r_hold} + {1'b0, data};
   assign w_sum  = {1'b0, r_above} + {1'b0, w_pair};
   // Max sum 1020, so +2 and >>2 never exceeds 255.
   assign w_avg  = 8'((w_sum + 10'd2) >> 2);

   assign w_emit  = valid & w_row_odd & w_col_odd;
   assign w_lb_wr = valid & ~w_row_odd & w_col_odd;
   assign w_lb_rd = valid & w_row_odd & ~w_col_odd;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_col <= '0;
         r_row <= '0;
      end else if (valid) begin
         if (w_last_col) begin
            r_col <= '0;
            r_row <= w_last_row ? '0 : r_row + 10'd1;
         end else begin
            r_col <= r_col + 10'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset)
         r_hold <= '0;
      else if (valid & ~w_col_odd)
         r_hold <= data;
   end

   // Read is launched on the even pixel and held across gaps.
   always_ff @(posedge clock) begin
      if (w_lb_wr)
         r_lbuf[w_idx] <= w_pair;
      if (w_lb_rd)
         r_above <= r_lbuf[w_idx];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_pend  <= 1'b0;
         r_dout  <= '0;
         r_ocol  <= '0;
         r_orow  <= '0;
         r_fdone <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_pend  <= w_emit;
         r_fdone <= valid & w_last_col & w_last_row;
         if (r_pend & fifo_full)
            r_ovf <= 1'b1;
         if (w_emit) begin
            r_dout <= w_avg;
            r_ocol <= r_col[9:1];
            r_orow <= r_row[9:1];
         end
      end
   end

   assign fifo_write   = r_pend & ~fifo_full;
   assign dataout      = r_dout;
   assign out_colcount = r_ocol;
   assign out_rowcount = r_orow;
   assign frame_done   = r_fdone;
   assign overflow     = r_ovf;

endmodule

// File: tb/tb_downsampler_2x2.sv
// tb_downsampler_2x2: random and directed frames against a block-average model.
// Expected blocks are queued at stimulus time and popped by a write monitor.
module tb_downsampler_2x2;

   localparam int NC = 16;
   localparam int NR = 8;
   localparam int BC = NC / 2;
   localparam int BR = NR / 2;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       valid = 1'b0;
   logic [7:0] data = 8'd0;
   logic       fifo_full = 1'b0;
   logic       fifo_write;
   logic [7:0] dataout;
   logic [8:0] out_colcount;
   logic [8:0] out_rowcount;
   logic       frame_done;
   logic       overflow;

   downsampler_2x2 #(.NUMCOL(NC), .NUMROW(NR)) u_dut (
      .clock        (clock),
      .reset        (reset),
      .valid        (valid),
      .data         (data),
      .fifo_full    (fifo_full),
      .fifo_write   (fifo_write),
      .dataout      (dataout),
      .out_colcount (out_colcount),
      .out_rowcount (out_rowcount),
      .frame_done   (frame_done),
      .overflow     (overflow)
   );

   always #5 clock = ~clock;

   typedef struct {
      int v;
      int c;
      int r;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   img [NR][NC];
   int   n_chk = 0;
   int   n_pass = 0;
   int   wr_cnt = 0;
   int   fd_cnt = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Reference: each block is the rounded mean of its four pixels.
   task automatic build_expect(input int dbi, input int dbj);
      int s;
      for (int bi = 0; bi < BR; bi++)
         for (int bj = 0; bj < BC; bj++) begin
            s = img[2*bi][2*bj] + img[2*bi][2*bj+1]
              + img[2*bi+1][2*bj] + img[2*bi+1][2*bj+1];
            if (!(bi == dbi && bj == dbj))
               q.push_back('{(s + 2) / 4, bj, bi});
         end
   endtask

   task automatic fill_pattern();
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            img[r][c] = 10 * r + c;
   endtask

   task automatic fill_random();
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            img[r][c] = int'($urandom_range(255, 0));
   endtask

   task automatic set_block(input int bj, input int a, input int b,
                            input int cc, input int d);
      img[0][2*bj] = a;
      img[0][2*bj+1] = b;
      img[1][2*bj] = cc;
      img[1][2*bj+1] = d;
   endtask

   task automatic fill_rounding();
      fill_random();
      set_block(0, 255, 255, 255, 255);
      set_block(1, 0, 0, 0, 1);
      set_block(2, 0, 0, 1, 1);
      set_block(3, 0, 1, 1, 1);
   endtask

   task automatic drive_frame(input bit gaps, input int dbi, input int dbj);
      int ng;
      build_expect(dbi, dbj);
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) begin
            ng = 0;
            while (gaps && ng < 3 && $urandom_range(1, 0) == 1) begin
               valid = 1'b0;
               @(posedge clock);
               #1;
               fifo_full = 1'b0;
               ng++;
            end
            valid = 1'b1;
            data = 8'(img[r][c]);
            @(posedge clock);
            #1;
            fifo_full = (r == 2 * dbi + 1) && (c == 2 * dbj + 1);
         end
      valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 40) begin
         @(posedge clock);
         n++;
      end
      fifo_full = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("drain_queue_empty", q.size(), 0);
   endtask

   always @(negedge clock) begin
      if (fifo_write) begin
         wr_cnt++;
         if (q.size() == 0) begin
            chk("unexpected_write", 1, 0);
         end else begin
            e = q.pop_front();
            chk("dataout", int'(dataout), e.v);
            chk("out_colcount", int'(out_colcount), e.c);
            chk("out_rowcount", int'(out_rowcount), e.r);
         end
      end
      if (frame_done) begin
         fd_cnt++;
         chk("frame_done_with_write", int'(fifo_write), 1);
         chk("frame_done_block",
             int'(out_rowcount) * BC + int'(out_colcount), BR * BC - 1);
      end
   end

   initial begin
      int w0;
      int f0;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_fifo_write", int'(fifo_write), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_dataout", int'(dataout), 0);
      chk("rst_out_col", int'(out_colcount), 0);
      chk("rst_out_row", int'(out_rowcount), 0);
      reset = 1'b0;

      fill_pattern();
      drive_frame(1'b0, -1, -1);
      drain();
      chk("frames_pattern", fd_cnt, 1);
      chk("writes_pattern", wr_cnt, BR * BC);

      fill_rounding();
      drive_frame(1'b0, -1, -1);
      for (int k = 0; k < 2; k++) begin
         fill_random();
         drive_frame(1'b1, -1, -1);
      end
      drain();
      chk("writes_gapped", wr_cnt, 4 * BR * BC);
      chk("overflow_before_drop", int'(overflow), 0);

      w0 = wr_cnt;
      fill_random();
      drive_frame(1'b1, 0, 1);
      drain();
      chk("overflow_after_drop", int'(overflow), 1);
      chk("writes_with_drop", wr_cnt - w0, BR * BC - 1);

      fill_random();
      drive_frame(1'b1, -1, -1);
      drain();
      chk("overflow_sticky", int'(overflow), 1);

      w0 = wr_cnt;
      fill_random();
      for (int c = 0; c < NC; c++) begin
         valid = 1'b1;
         data = 8'(img[0][c]);
         @(posedge clock);
         #1;
      end
      valid = 1'b1;
      data = 8'(img[1][0]);
      @(posedge clock);
      #1;
      data = 8'(img[1][1]);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      valid = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      chk("no_write_after_reset", wr_cnt - w0, 0);
      chk("overflow_cleared", int'(overflow), 0);
      chk("fifo_write_idle", int'(fifo_write), 0);

      f0 = fd_cnt;
      fill_random();
      drive_frame(1'b0, -1, -1);
      fill_random();
      drive_frame(1'b0, -1, -1);
      drain();
      chk("frame_done_b2b", fd_cnt - f0, 2);
      chk("overflow_end", int'(overflow), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1);
   end

endmodule
